// File: rtl/apb_master_if.sv
// Bundle of the command/response handshake and the APB bus signals for apb_master.
// Command: a request transfers on a rising edge where cmd_valid && cmd_ready. Response: rsp_valid is a one-cycle pulse with no ready.
interface apb_master_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_timeout;
    logic [DATA_W-1:0] rsp_rdata;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
        output cmd_ready, rsp_valid, rsp_timeout, rsp_rdata,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
        input  cmd_ready, rsp_valid, rsp_timeout, rsp_rdata,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB master: turns one command into a SETUP/ACCESS transfer,
// aborting with rsp_timeout when the slave holds PREADY low for TIMEOUT access cycles.
module apb_master #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic       PCLK,
    input  logic       PRESET,
    apb_master_if.master bus,
    output logic [1:0] dbg_state
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              cmd_ready;

    // Reset blocks acceptance even though the state register already reads IDLE.
    assign cmd_ready = (state_q == IDLE) && !PRESET;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = 1'b0;
        rsp_timeout_d = rsp_timeout_q;
        rsp_rdata_d   = rsp_rdata_q;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready) begin
                    state_d   = SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    paddr_d   = bus.cmd_addr;
                    pwrite_d  = bus.cmd_write;
                    pwdata_d  = bus.cmd_write ? bus.cmd_wdata : '0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            ACCESS: begin
                // A ready slave wins over a timeout landing on the same edge.
                if (bus.PREADY) begin
                    state_d       = IDLE;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = pwrite_q ? '0 : bus.PRDATA;
                end else if (cnt_q + 8'd1 == TIMEOUT_C) begin
                    state_d       = IDLE;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_rdata_q   <= rsp_rdata_d;
        end
    end

    assign bus.cmd_ready   = cmd_ready;
    assign bus.PSEL        = psel_q;
    assign bus.PENABLE     = penable_q;
    assign bus.PWRITE      = pwrite_q;
    assign bus.PADDR       = paddr_q;
    assign bus.PWDATA      = pwdata_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign dbg_state       = state_q;
endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: each transfer is expanded into its expected per-cycle
// bus picture, and a single compare process checks the DUT against it every cycle.
module tb_apb_master;
    localparam int TIMEOUT = 16;

    typedef struct packed {
        logic       rst;
        logic       cmd_ready;
        logic       psel;
        logic       penable;
        logic       pwrite;
        logic [7:0] paddr;
        logic [7:0] pwdata;
        logic       rsp_valid;
        logic       rsp_timeout;
        logic [7:0] rsp_rdata;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg_state;

    exp_t       exp_q[$];
    exp_t       e;
    int         n_cmp = 0;
    int         n_err = 0;
    int         pen_run = 0;
    int         last_pen_run = 0;
    int         rsp_count = 0;
    logic [7:0] last_rdata = '0;
    logic       last_timeout = 1'b0;

    apb_master_if #(.ADDR_W(8), .DATA_W(8)) bus_if ();

    apb_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TIMEOUT)) dut (
        .PCLK     (clk),
        .PRESET   (rst),
        .bus      (bus_if),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // expected-vector builders
    function automatic exp_t e_idle();
        exp_t v;
        v = '0;
        v.cmd_ready = 1'b1;
        return v;
    endfunction

    function automatic exp_t e_reset();
        exp_t v;
        v = '0;
        v.rst = 1'b1;
        return v;
    endfunction

    function automatic exp_t e_bus(input logic pen, input logic wr, input logic [7:0] addr,
                                   input logic [7:0] wdata);
        exp_t v;
        v = '0;
        v.psel    = 1'b1;
        v.penable = pen;
        v.pwrite  = wr;
        v.paddr   = addr;
        v.pwdata  = wr ? wdata : 8'h00;
        return v;
    endfunction

    function automatic exp_t e_rsp(input logic to, input logic [7:0] rdata);
        exp_t v;
        v = '0;
        v.cmd_ready   = 1'b1;
        v.rsp_valid   = 1'b1;
        v.rsp_timeout = to;
        v.rsp_rdata   = rdata;
        return v;
    endfunction

    // compare process: one expected vector per clock
    always @(posedge clk) begin
        #1;
        if (bus_if.PENABLE === 1'b1) pen_run++;
        else if (pen_run > 0) begin
            last_pen_run = pen_run;
            pen_run = 0;
        end
        if (bus_if.rsp_valid === 1'b1) begin
            rsp_count++;
            last_rdata   = bus_if.rsp_rdata;
            last_timeout = bus_if.rsp_timeout;
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("cmd_ready", bus_if.cmd_ready, e.cmd_ready);
            chk("psel", bus_if.PSEL, e.psel);
            chk("penable", bus_if.PENABLE, e.penable);
            chk("rsp_valid", bus_if.rsp_valid, e.rsp_valid);
            if (e.psel) begin
                chk("pwrite", bus_if.PWRITE, e.pwrite);
                chk("paddr", bus_if.PADDR, e.paddr);
                chk("pwdata", bus_if.PWDATA, e.pwdata);
            end
            if (e.rsp_valid) begin
                chk("rsp_timeout", bus_if.rsp_timeout, e.rsp_timeout);
                chk("rsp_rdata", bus_if.rsp_rdata, e.rsp_rdata);
            end
            if (e.rst) begin
                chk("rst_pwrite", bus_if.PWRITE, 0);
                chk("rst_paddr", bus_if.PADDR, 0);
                chk("rst_pwdata", bus_if.PWDATA, 0);
                chk("rst_rsp_rdata", bus_if.rsp_rdata, 0);
                chk("rst_rsp_timeout", bus_if.rsp_timeout, 0);
                chk("rst_state", dbg_state, 0);
            end
        end
    end

    // driver tasks: inputs change at negedge, expectation is for the cycle after the next posedge
    task automatic tick(input exp_t v);
        exp_q.push_back(v);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus_if.cmd_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus_if.PREADY = 1'($urandom_range(0, 1));
            bus_if.PRDATA = 8'($urandom_range(0, 255));
            tick(e_idle());
        end
    endtask

    task automatic reset_cycles(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) tick(e_reset());
        rst = 1'b0;
    endtask

    task automatic do_txn(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                          input logic [7:0] rdata, input int waits);
        logic to;
        int   n_acc;
        to    = (waits >= TIMEOUT);
        n_acc = to ? TIMEOUT : waits + 1;
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_write = wr;
        bus_if.cmd_addr  = addr;
        bus_if.cmd_wdata = wdata;
        bus_if.PREADY    = 1'b0;
        bus_if.PRDATA    = 8'h00;
        tick(e_bus(1'b0, wr, addr, wdata));
        // junk on command and slave side while busy
        bus_if.cmd_write = ~wr;
        bus_if.cmd_addr  = ~addr;
        bus_if.cmd_wdata = ~wdata;
        bus_if.PREADY    = 1'b1;
        bus_if.PRDATA    = ~rdata;
        tick(e_bus(1'b1, wr, addr, wdata));
        for (int i = 0; i < n_acc; i++) begin
            bus_if.PREADY = (i >= waits);
            bus_if.PRDATA = (i >= waits) ? rdata : ~rdata;
            if (i == n_acc - 1) tick(e_rsp(to, (to || wr) ? 8'h00 : rdata));
            else tick(e_bus(1'b1, wr, addr, wdata));
        end
    endtask

    initial begin
        int cnt_before;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_write = 1'b0;
        bus_if.cmd_addr  = '0;
        bus_if.cmd_wdata = '0;
        bus_if.PREADY    = 1'b0;
        bus_if.PRDATA    = '0;
        @(negedge clk);
        reset_cycles(3);
        idle(2);

        // write 0xA5 to 0x10, zero wait
        do_txn(1'b1, 8'h10, 8'hA5, 8'h00, 0);
        chk("lit_w_pen_cycles", last_pen_run, 1);
        chk("lit_w_timeout", last_timeout, 0);
        idle(1);

        // read 0x20, three wait states
        do_txn(1'b0, 8'h20, 8'h00, 8'h3C, 3);
        chk("lit_r_pen_cycles", last_pen_run, 4);
        chk("lit_r_rdata", last_rdata, 8'h3C);
        chk("lit_r_timeout", last_timeout, 0);
        idle(1);

        // PREADY stuck low
        do_txn(1'b0, 8'h30, 8'h00, 8'h77, 100);
        chk("lit_to_pen_cycles", last_pen_run, 16);
        chk("lit_to_timeout", last_timeout, 1);
        chk("lit_to_rdata", last_rdata, 8'h00);
        idle(1);

        // back-to-back write then read
        cnt_before = rsp_count;
        do_txn(1'b1, 8'h01, 8'h5A, 8'h00, 0);
        do_txn(1'b0, 8'h02, 8'h00, 8'hC3, 1);
        chk("lit_b2b_rsp_count", rsp_count - cnt_before, 2);
        chk("lit_b2b_rdata", last_rdata, 8'hC3);
        idle(1);

        // reset during ACCESS with PREADY low
        cnt_before = rsp_count;
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_write = 1'b0;
        bus_if.cmd_addr  = 8'h66;
        bus_if.PREADY    = 1'b0;
        tick(e_bus(1'b0, 1'b0, 8'h66, 8'h00));
        tick(e_bus(1'b1, 1'b0, 8'h66, 8'h00));
        tick(e_bus(1'b1, 1'b0, 8'h66, 8'h00));
        rst = 1'b1;
        tick(e_reset());
        rst = 1'b0;
        idle(2);
        chk("lit_rst_no_rsp", rsp_count - cnt_before, 0);
        do_txn(1'b1, 8'h44, 8'h99, 8'h00, 2);
        chk("lit_rst_next_rsp", rsp_count - cnt_before, 1);
        idle(1);

        // PREADY rises on the TIMEOUT-th wait cycle
        do_txn(1'b0, 8'h55, 8'h00, 8'hE7, TIMEOUT - 1);
        chk("lit_edge_pen_cycles", last_pen_run, 16);
        chk("lit_edge_timeout", last_timeout, 0);
        chk("lit_edge_rdata", last_rdata, 8'hE7);
        idle(1);

        // one cycle too late: timeout
        do_txn(1'b0, 8'h56, 8'h00, 8'h12, TIMEOUT);
        chk("lit_late_timeout", last_timeout, 1);

        // a few more mixed transfers
        do_txn(1'b1, 8'hFF, 8'h00, 8'hAA, 5);
        do_txn(1'b0, 8'h00, 8'hFF, 8'hFF, 0);
        idle(2);

        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter ADDR_W, default 8, PADDR/cmd_addr width in bits.
REQ-002 Parameter DATA_W, default 8, PWDATA/PRDATA/cmd_wdata/rsp_rdata width in bits.
REQ-003 Parameter TIMEOUT, default 16, maximum ACCESS cycles with PREADY low before abort; legal range 1..255.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 PCLK  in  1  system clock; all state changes on rising edge.
REQ-006 PRESET  in  1  synchronous active-high reset.
REQ-007 cmd_valid  in  1  request present.
REQ-008 cmd_ready  out  1  master can accept a request this cycle.
REQ-009 cmd_write  in  1  1 = write, 0 = read.
REQ-010 cmd_addr  in  ADDR_W  transfer address.
REQ-011 cmd_wdata  in  DATA_W  write data.
REQ-012 rsp_valid  out  1  one-cycle pulse, transfer finished.
REQ-013 rsp_rdata  out  DATA_W  read data, valid with rsp_valid.
REQ-014 rsp_timeout  out  1  transfer aborted by timeout, valid with rsp_valid.
REQ-015 PSEL  out  1  APB select.
REQ-016 PENABLE  out  1  APB enable (access phase).
REQ-017 PWRITE  out  1  APB direction.
REQ-018 PADDR  out  ADDR_W  APB address.
REQ-019 PWDATA  out  DATA_W  APB write data.
REQ-020 PRDATA  in  DATA_W  APB read data from slave.
REQ-021 PREADY  in  1  APB slave ready.

Function
REQ-022 FSM states IDLE, SETUP, ACCESS; all APB outputs and rsp_* registered.
REQ-023 cmd_ready = 1 only in IDLE (combinational from state); request accepted on edge where cmd_valid && cmd_ready.
REQ-024 IDLE -> SETUP on accept: PSEL=1, PENABLE=0, PADDR=cmd_addr, PWRITE=cmd_write, PWDATA=cmd_wdata on write, 0 on read.
REQ-025 SETUP -> ACCESS unconditionally after one cycle: PENABLE=1, PSEL stays 1.
REQ-026 PADDR, PWRITE, PWDATA held constant from SETUP through last ACCESS cycle.
REQ-027 ACCESS with PREADY=1 sampled -> IDLE: PSEL=0, PENABLE=0, rsp_valid=1 next cycle, rsp_timeout=0.
REQ-028 On read completion rsp_rdata = PRDATA sampled at the completing edge; on write completion rsp_rdata = 0.
REQ-029 Wait counter cleared on entry to ACCESS, increments each ACCESS cycle with PREADY=0.
REQ-030 Counter reaches TIMEOUT with PREADY still 0 -> IDLE: PSEL=0, PENABLE=0, rsp_valid=1, rsp_timeout=1, rsp_rdata=0.
REQ-031 PREADY=1 on the same edge the counter would reach TIMEOUT: normal completion wins, rsp_timeout=0.
REQ-032 Minimum latency: accept edge k -> rsp_valid high in cycle after edge k+2; each wait state adds one cycle.
REQ-033 rsp_valid high exactly one cycle per accepted request; no response backpressure.
REQ-034 Back-to-back: cmd_ready=1 in the same cycle rsp_valid=1; next SETUP starts on the following edge; PSEL drops for at least one cycle between transfers.
REQ-035 PRDATA and PREADY ignored outside ACCESS.
REQ-036 cmd_* ignored when cmd_ready=0.

Reset
REQ-037 PRESET=1 sampled -> state IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_timeout=0, counter=0.
REQ-038 Reset in SETUP or ACCESS aborts the transfer immediately; no rsp_valid for the aborted request.
REQ-039 cmd_ready=0 while PRESET=1; first accept possible on first edge with PRESET=0.

Verification
REQ-040 Write 0xA5 to addr 0x10, PREADY tied 1 -> PSEL one cycle with PENABLE=0, then one cycle PENABLE=1, PWRITE=1, PADDR=0x10, PWDATA=0xA5; rsp_valid next cycle, rsp_timeout=0.
REQ-041 Read addr 0x20, slave drives PRDATA=0x3C, PREADY low 3 ACCESS cycles -> PENABLE high 4 cycles, rsp_rdata=0x3C, rsp_timeout=0.
REQ-042 Read with PREADY stuck 0, TIMEOUT=16 -> 16 ACCESS cycles, then PSEL=0, rsp_valid=1, rsp_timeout=1, rsp_rdata=0.
REQ-043 cmd_valid held high with write 0x01 then read 0x02 -> two transfers, PSEL low one cycle between, two rsp_valid pulses, addresses in order.
REQ-044 PRESET asserted during ACCESS with PREADY=0 -> all outputs at reset values next cycle, no rsp_valid; next request completes normally.
REQ-045 PREADY rises on the TIMEOUT-th wait cycle -> normal completion, rsp_timeout=0, correct rsp_rdata.
